// File: rtl/subckt_seq_pkg.sv
// Shared types and helpers for the sub-circuit activity sequencers.
package subckt_seq_pkg;

  // Sequencer control states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } seq_state_e;

  // Fibonacci feedback mask for a 4-bit maximal LFSR (x^4 + x^3 + 1).
  localparam logic [3:0] LFSR_TAPS_DEFAULT = 4'b1100;

  // Number of set bits in a vector of up to 16 bits (zero-extend narrower vectors).
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/subckt_activity_sequencer_if.sv
// Control/result bus between the experiment controller, the sequencer and the sub-circuit.
interface subckt_activity_sequencer_if #(
  parameter int N_IN  = 4,
  parameter int CNT_W = 16
);
  logic             start;
  logic             mode;
  logic [CNT_W-1:0] num_vec;
  logic [N_IN-1:0]  seed;
  logic [N_IN-1:0]  vec_o;
  logic             dut_out_i;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] out_toggles;
  logic [CNT_W-1:0] in_toggles;
  logic [CNT_W-1:0] ones_cnt;

  // Controller side: issues runs, presents the sub-circuit output, reads results.
  modport master (
    output start, mode, num_vec, seed, dut_out_i,
    input  vec_o, busy, done, out_toggles, in_toggles, ones_cnt
  );

  // Sequencer side.
  modport slave (
    input  start, mode, num_vec, seed, dut_out_i,
    output vec_o, busy, done, out_toggles, in_toggles, ones_cnt
  );
endinterface

// File: rtl/subckt_activity_sequencer_vec_gen.sv
// Next-vector generator: binary increment (mode 0) or one Fibonacci LFSR step (mode 1).
module subckt_activity_sequencer_vec_gen #(
  parameter int              N_IN = 4,
  parameter logic [N_IN-1:0] TAPS = N_IN'(4'b1100)
) (
  input  logic            mode_i,
  input  logic [N_IN-1:0] cur_i,
  output logic [N_IN-1:0] nxt_o
);
  localparam logic [N_IN-1:0] VEC_ONE = N_IN'(1'b1);

  // Select increment-with-wrap or shift-left with XOR feedback of the tapped bits.
  always_comb begin
    nxt_o = cur_i;
    if (mode_i == 1'b0) begin
      nxt_o = cur_i + VEC_ONE;
    end else begin
      nxt_o = {cur_i[N_IN-2:0], ^(cur_i & TAPS)};
    end
  end
endmodule

// File: rtl/subckt_activity_sequencer.sv
// Applies vectors to a small combinational sub-circuit, samples its output after
// a settle time, and accumulates saturating switching-activity counts.
module subckt_activity_sequencer
  import subckt_seq_pkg::*;
#(
  parameter int              N_IN       = 4,
  parameter int              CNT_W      = 16,
  parameter int              SETTLE_CYC = 1,
  parameter logic [N_IN-1:0] LFSR_TAPS  = N_IN'(LFSR_TAPS_DEFAULT)
) (
  input logic                      clk,
  input logic                      rst_n,
  subckt_activity_sequencer_if.slave bus
);
  localparam int               SW          = $clog2(SETTLE_CYC + 1);
  localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [SW-1:0]    SETTLE_ONE  = SW'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [N_IN-1:0]  VEC_ZERO    = {N_IN{1'b0}};
  localparam logic [N_IN-1:0]  VEC_ONE     = N_IN'(1'b1);

  // Saturating add of a small increment; clamps at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [4:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W + 1)'(b);
    if (s[CNT_W]) begin
      return CNT_MAX;
    end else begin
      return s[CNT_W-1:0];
    end
  endfunction

  seq_state_e       state_q, state_d;
  logic [N_IN-1:0]  vec_q, vec_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] num_vec_q, num_vec_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [CNT_W-1:0] smp_q, smp_d;
  logic             prev_out_q, prev_out_d;
  logic [CNT_W-1:0] out_tog_q, out_tog_d;
  logic [CNT_W-1:0] in_tog_q, in_tog_d;
  logic [CNT_W-1:0] ones_q, ones_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [N_IN-1:0]  vec_nxt;
  logic [4:0]       step_pc;

  subckt_activity_sequencer_vec_gen #(
    .N_IN (N_IN),
    .TAPS (LFSR_TAPS)
  ) u_vec_gen (
    .mode_i (mode_q),
    .cur_i  (vec_q),
    .nxt_o  (vec_nxt)
  );

  assign step_pc = popcount16(16'(vec_nxt ^ vec_q));

  // Next-state and datapath update for the apply/settle/sample sequence.
  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    mode_d     = mode_q;
    num_vec_d  = num_vec_q;
    settle_d   = settle_q;
    smp_d      = smp_q;
    prev_out_d = prev_out_q;
    out_tog_d  = out_tog_q;
    in_tog_d   = in_tog_q;
    ones_d     = ones_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          out_tog_d  = CNT_ZERO;
          in_tog_d   = CNT_ZERO;
          ones_d     = CNT_ZERO;
          prev_out_d = 1'b0;
          smp_d      = CNT_ZERO;
          settle_d   = {SW{1'b0}};
          if (bus.num_vec != CNT_ZERO) begin
            mode_d    = bus.mode;
            num_vec_d = bus.num_vec;
            if (bus.mode == 1'b0) begin
              vec_d = VEC_ZERO;
            end else begin
              // An all-zero seed would lock the LFSR, so substitute 1.
              vec_d = (bus.seed == VEC_ZERO) ? VEC_ONE : bus.seed;
            end
            state_d = APPLY;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      APPLY: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = {SW{1'b0}};
          state_d  = SAMPLE;
        end else begin
          settle_d = settle_q + SETTLE_ONE;
        end
      end
      SAMPLE: begin
        ones_d = bus.dut_out_i ? sat_add(ones_q, 5'd1) : ones_q;
        // The first sample has no predecessor, so it never counts as a toggle.
        if ((smp_q != CNT_ZERO) && (bus.dut_out_i != prev_out_q)) begin
          out_tog_d = sat_add(out_tog_q, 5'd1);
        end else begin
          out_tog_d = out_tog_q;
        end
        prev_out_d = bus.dut_out_i;
        if (smp_q == (num_vec_q - CNT_ONE)) begin
          state_d = DONE;
        end else begin
          smp_d    = smp_q + CNT_ONE;
          vec_d    = vec_nxt;
          in_tog_d = sat_add(in_tog_q, step_pc);
          state_d  = APPLY;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      vec_q      <= VEC_ZERO;
      mode_q     <= 1'b0;
      num_vec_q  <= CNT_ZERO;
      settle_q   <= {SW{1'b0}};
      smp_q      <= CNT_ZERO;
      prev_out_q <= 1'b0;
      out_tog_q  <= CNT_ZERO;
      in_tog_q   <= CNT_ZERO;
      ones_q     <= CNT_ZERO;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      mode_q     <= mode_d;
      num_vec_q  <= num_vec_d;
      settle_q   <= settle_d;
      smp_q      <= smp_d;
      prev_out_q <= prev_out_d;
      out_tog_q  <= out_tog_d;
      in_tog_q   <= in_tog_d;
      ones_q     <= ones_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.vec_o       = vec_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.out_toggles = out_tog_q;
  assign bus.in_toggles  = in_tog_q;
  assign bus.ones_cnt    = ones_q;

endmodule
